dp_mem_responder: RTL and testbench
===================================

# dp_mem_responder

Cache-side responder for the datapath/cache interface. It accepts the pipeline's instruction-fetch and data-access requests and arbitrates them onto one single-ported RAM port. It returns `ihit`/`dhit` pulses with the corresponding load data, and it handles halt, RAM error and a stuck-RAM watchdog. It sits between the datapath and the RAM model and stands in for real caches until those exist.

## Interface
- `WATCHDOG`, default 255: maximum number of cycles spent in a BUSY state before the access is aborted.
- `CLK` in 1: the single clock.
- `nRST` in 1: reset. Asynchronous and active-high; it is asserted when high.
- `halt` in 1: the pipeline has retired a halt.
- `imemREN` in 1: instruction read request.
- `imemaddr` in 32: instruction word address.
- `dmemREN` in 1: data read request.
- `dmemWEN` in 1: data write request.
- `dmemaddr` in 32: data address.
- `dmemstore` in 32: write data.
- `ihit` out 1: one-cycle pulse; the instruction fetch is complete.
- `imemload` out 32: fetched instruction, valid while `ihit` is high.
- `dhit` out 1: one-cycle pulse; the data access is complete.
- `dmemload` out 32: read data, valid while `dhit` is high.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2 (`ramstate_t`): RAM status, one of FREE, BUSY, ACCESS, ERROR.
- `memerr` out 1: sticky flag; set on RAM ERROR or on a watchdog abort.

## Operation
- States are IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D and HALTED.
- Reset puts the block in IDLE. All outputs reset to 0, `memerr` reset to 0, the watchdog counter reset to 0.
- Arbitration in IDLE, in priority order:
  - `halt` → HALTED.
  - `dmemREN|dmemWEN` → BUSY_D. Data has priority because it is the older instruction.
  - `imemREN` → BUSY_I.
  - Otherwise remain in IDLE.
- `dmemREN` and `dmemWEN` both high is illegal. Treat it as a write.
- BUSY_x:
  - Drive the RAM combinationally from the granted requester's inputs.
  - The datapath holds its request stable until its hit.
  - The grant is locked; a new data request never pre-empts an in-flight fetch.
  - On `ramstate==ACCESS`: register `ramload` into the load register and go to RESP_x.
  - On `ramstate==ERROR`: set `memerr`, load 32'hBAD1BAD1 and go to RESP_x.
  - When the watchdog counter reaches `WATCHDOG`: same action as ERROR.
- RESP_x:
  - Assert `ihit` or `dhit` for exactly one cycle; the load output is driven from the register.
  - RAM enables are low.
  - Next state is IDLE. This guarantees one dead cycle so a held request is not served twice.
- Writes also pulse `dhit`. `dmemload` is don't-care on a write; drive the captured word.
- `halt` arriving while in BUSY/RESP is ignored until the block returns to IDLE. The outstanding access always completes.
- HALTED: no grants, RAM enables low, hits low. The only exit is reset.
- `memerr` clears only on reset.
- The watchdog counter is 8 bits wide. It counts cycles spent in BUSY_x and clears on leaving BUSY_x.

## Timing
- Request present in IDLE at cycle t:
  - RAM enables are high from t+1.
  - If ACCESS arrives at cycle a, the hit is at a+1.
  - With a zero-wait RAM (ACCESS at t+1), the hit is at t+2.
- Back-to-back accesses take at least 3 cycles each: grant, access, response.
- Outputs are registered except the RAM address, data and enables, which are combinational from state and inputs.
- Reset asserted mid-access drops the RAM enables immediately (asynchronously) and discards the access. No hit is produced.

## Configuration
- `DP_MEM_RESPONDER_STATS_EN` defined: add outputs `icount`, `dcount` and `stallcount`, each 32 bits.
  - `icount` counts instruction hits.
  - `dcount` counts data hits.
  - `stallcount` counts cycles spent in BUSY_x.
  - All three saturate at all-ones and reset to 0.
- Macro undefined: none of these ports or counters exist; behaviour is otherwise identical.

## Structure
- `ramstate_t` and the word width constant come from `cpu_types_pkg`.
- Add to `cpu_types_pkg`:
  - a state enum `dmr_state_t`;
  - the constant `BAD_WORD = 32'hBAD1BAD1`.
- One sub-module, `watchdog_counter`: a saturating up-counter with clear, parameterised by `WATCHDOG`.

## Test plan
- Zero-wait RAM, `imemREN=1`, `imemaddr=0x40`, `ramload=0x8C220004` → `ihit` at t+2 for 1 cycle, `imemload=0x8C220004`, then a dead cycle.
- Simultaneous `imemREN=1` and `dmemREN=1` (`dmemaddr=0x100`, ramload 0xDEAD) → `dhit` first, `dmemload=0xDEAD`; `ihit` 3 cycles later.
- `imemREN` granted, RAM BUSY for 4 cycles, `dmemWEN` arriving mid-wait → the fetch completes first; `ramWEN` high only after the RESP_I→IDLE transition; `ramstore=dmemstore=0x1234`.
- RAM stuck at BUSY → abort after 255 BUSY cycles; hit with load 0xBAD1BAD1 and `memerr=1`, which stays high until reset.
- `halt=1` during BUSY_D → `dhit` delivered, then HALTED; a later `imemREN` produces no `ramREN`. Assert `nRST` → IDLE, `memerr=0`.
- With STATS_EN: 3 fetches plus 2 loads against a RAM with 1 wait cycle → `icount=3`, `dcount=2`, `stallcount=10`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath/cache types: word width, RAM status, responder FSM states
// and the saturating-increment helper used by the statistics counters.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    DMR_IDLE   = 3'd0,
    DMR_BUSY_I = 3'd1,
    DMR_BUSY_D = 3'd2,
    DMR_RESP_I = 3'd3,
    DMR_RESP_D = 3'd4,
    DMR_HALTED = 3'd5
  } dmr_state_t;

  // Word returned to the pipeline when the RAM errors out or hangs.
  localparam word_t BAD_WORD = 32'hBAD1BAD1;

  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + word_t'(1);
  endfunction

endpackage

// File: rtl/dp_mem_responder_watchdog_counter.sv
// watchdog_counter: 8-bit saturating up-counter with synchronous clear; flags
// expiry once the count reaches WATCHDOG.
module watchdog_counter #(
  parameter int unsigned WATCHDOG = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(WATCHDOG);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/dp_mem_responder.sv
// dp_mem_responder: arbitrates fetch and data requests onto one RAM port and
// returns hit pulses. Optional counters via DP_MEM_RESPONDER_STATS_EN.
module dp_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned WATCHDOG = 255
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       halt,
  input  logic       imemREN,
  input  word_t      imemaddr,
  input  logic       dmemREN,
  input  logic       dmemWEN,
  input  word_t      dmemaddr,
  input  word_t      dmemstore,
  output logic       ihit,
  output word_t      imemload,
  output logic       dhit,
  output word_t      dmemload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  ramstate_t  ramstate,
  output logic       memerr,
`ifdef DP_MEM_RESPONDER_STATS_EN
  output word_t      icount,
  output word_t      dcount,
  output word_t      stallcount,
`endif
  output dmr_state_t dbg_state
);

  dmr_state_t state_q, state_d;
  word_t      load_q, load_d;
  logic       ihit_q, ihit_d;
  logic       dhit_q, dhit_d;
  logic       memerr_q, memerr_d;

  logic busy_i, busy_d, busy;
  logic ram_done, ram_fail, finish;
  logic wd_expired;

  watchdog_counter #(
    .WATCHDOG(WATCHDOG)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (nRST),
    .clr    (~busy),
    .en     (busy),
    .expired(wd_expired)
  );

  always_comb begin
    busy_i   = (state_q == DMR_BUSY_I);
    busy_d   = (state_q == DMR_BUSY_D);
    busy     = busy_i | busy_d;
    ram_done = busy & (ramstate == ACCESS);
    // ERROR and watchdog expiry abort the access identically.
    ram_fail = busy & ~ram_done & ((ramstate == ERROR) | wd_expired);
    finish   = ram_done | ram_fail;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DMR_IDLE: begin
        if (halt)                    state_d = DMR_HALTED;
        else if (dmemREN | dmemWEN)  state_d = DMR_BUSY_D;
        else if (imemREN)            state_d = DMR_BUSY_I;
      end
      DMR_BUSY_I: if (finish) state_d = DMR_RESP_I;
      DMR_BUSY_D: if (finish) state_d = DMR_RESP_D;
      DMR_RESP_I: state_d = DMR_IDLE;
      DMR_RESP_D: state_d = DMR_IDLE;
      DMR_HALTED: state_d = DMR_HALTED;
      default:    state_d = DMR_IDLE;
    endcase
  end

  always_comb begin
    load_d = load_q;
    if (ram_done) begin
      load_d = ramload;
    end else if (ram_fail) begin
      load_d = BAD_WORD;
    end
    ihit_d   = busy_i & finish;
    dhit_d   = busy_d & finish;
    memerr_d = memerr_q | ram_fail;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q  <= DMR_IDLE;
      load_q   <= '0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      ihit_q   <= ihit_d;
      dhit_q   <= dhit_d;
      memerr_q <= memerr_d;
    end
  end

  // RAM port follows the granted requester; a write wins over a read.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (busy_i) begin
      ramREN  = 1'b1;
      ramaddr = imemaddr;
    end else if (busy_d) begin
      ramWEN   = dmemWEN;
      ramREN   = dmemREN & ~dmemWEN;
      ramaddr  = dmemaddr;
      ramstore = dmemstore;
    end
  end

  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign imemload  = load_q;
  assign dmemload  = load_q;
  assign memerr    = memerr_q;
  assign dbg_state = state_q;

`ifdef DP_MEM_RESPONDER_STATS_EN
  word_t icount_q, icount_d;
  word_t dcount_q, dcount_d;
  word_t stall_q, stall_d;

  always_comb begin
    icount_d = ihit_q ? sat_inc(icount_q) : icount_q;
    dcount_d = dhit_q ? sat_inc(dcount_q) : dcount_q;
    stall_d  = busy   ? sat_inc(stall_q)  : stall_q;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
      stall_q  <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
      stall_q  <= stall_d;
    end
  end

  assign icount     = icount_q;
  assign dcount     = dcount_q;
  assign stallcount = stall_q;
`endif

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed bench for dp_mem_responder with a small programmable RAM model.
// Stats checks are included when DP_MEM_RESPONDER_STATS_EN is defined.
module tb_dp_mem_responder;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       halt;
  logic       imemREN;
  word_t      imemaddr;
  logic       dmemREN;
  logic       dmemWEN;
  word_t      dmemaddr;
  word_t      dmemstore;
  logic       ihit;
  word_t      imemload;
  logic       dhit;
  word_t      dmemload;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  ramstate_t  ramstate;
  logic       memerr;
  dmr_state_t dbg_state;
`ifdef DP_MEM_RESPONDER_STATS_EN
  word_t      icount;
  word_t      dcount;
  word_t      stallcount;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // RAM model: mode 0 normal (ACCESS after ram_wait cycles), 1 stuck BUSY, 2 ERROR
  int    ram_mode;
  int    ram_wait;
  int    wait_cnt;
  word_t ram_rdata;
  word_t wr_addr;
  word_t wr_data;

  dp_mem_responder #(.WATCHDOG(255)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .halt      (halt),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .ihit      (ihit),
    .imemload  (imemload),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .memerr    (memerr),
`ifdef DP_MEM_RESPONDER_STATS_EN
    .icount    (icount),
    .dcount    (dcount),
    .stallcount(stallcount),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge nRST) begin
    if (nRST) wait_cnt <= 0;
    else if (ramREN || ramWEN) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge CLK) begin
    if (ramWEN && ramstate == ACCESS) begin
      wr_addr <= ramaddr;
      wr_data <= ramstore;
    end
  end

  always_comb begin
    ramstate = FREE;
    if (ramREN || ramWEN) begin
      if (ram_mode == 1)              ramstate = BUSY;
      else if (ram_mode == 2)         ramstate = ERROR;
      else if (wait_cnt >= ram_wait)  ramstate = ACCESS;
      else                            ramstate = BUSY;
    end
  end

  assign ramload = ram_rdata;

  // checkers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input word_t obs, input word_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input dmr_state_t obs, input dmr_state_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver helpers; wait_hit counts negedges until the hit shows, bounded by limit
  task automatic wait_hit(input bit want_d, input int limit, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(want_d ? dhit : ihit) && n < limit);
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    nRST = 1'b0;
  endtask

  int n;

  initial begin
    nRST = 1'b1; halt = 1'b0;
    imemREN = 1'b0; imemaddr = '0;
    dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    ram_mode = 0; ram_wait = 0; ram_rdata = '0;

    // reset state
    @(negedge CLK);
    chk_st("rst_state", dbg_state, DMR_IDLE);
    chk1("rst_ihit", ihit, 1'b0);
    chk1("rst_dhit", dhit, 1'b0);
    chk1("rst_memerr", memerr, 1'b0);
    chk1("rst_ramren", ramREN, 1'b0);
    chk32("rst_imemload", imemload, 32'h0);
    @(negedge CLK);
    nRST = 1'b0;

    // zero-wait fetch
    imemREN = 1'b1; imemaddr = 32'h40; ram_rdata = 32'h8C220004;
    @(negedge CLK);
    chk_st("f0_busy", dbg_state, DMR_BUSY_I);
    chk1("f0_ramren", ramREN, 1'b1);
    chk32("f0_ramaddr", ramaddr, 32'h40);
    chk1("f0_no_early_hit", ihit, 1'b0);
    @(negedge CLK);
    chk1("f0_ihit", ihit, 1'b1);
    chk32("f0_imemload", imemload, 32'h8C220004);
    chk1("f0_resp_ramren", ramREN, 1'b0);
    imemREN = 1'b0;
    @(negedge CLK);
    chk1("f0_pulse_end", ihit, 1'b0);
    chk_st("f0_dead", dbg_state, DMR_IDLE);

    // simultaneous fetch and load: data first
    imemREN = 1'b1; imemaddr = 32'h44;
    dmemREN = 1'b1; dmemaddr = 32'h100; ram_rdata = 32'hDEAD;
    wait_hit(1'b1, 10, n);
    chk_int("pri_dhit_lat", n, 2);
    chk32("pri_dmemload", dmemload, 32'hDEAD);
    chk1("pri_no_ihit", ihit, 1'b0);
    dmemREN = 1'b0; ram_rdata = 32'h8C220004;
    wait_hit(1'b0, 10, n);
    chk_int("pri_ihit_lat", n, 3);
    chk32("pri_imemload", imemload, 32'h8C220004);
    imemREN = 1'b0;
    @(negedge CLK);

    // locked fetch grant; write arrives mid-wait
    ram_wait = 4; imemREN = 1'b1; imemaddr = 32'h48; ram_rdata = 32'h11112222;
    @(negedge CLK);
    for (int k = 2; k <= 5; k++) begin
      @(negedge CLK);
      if (k == 2) begin
        dmemWEN = 1'b1; dmemaddr = 32'h200; dmemstore = 32'h1234;
      end
      chk1("lock_no_ramwen", ramWEN, 1'b0);
    end
    @(negedge CLK);
    chk1("lock_ihit", ihit, 1'b1);
    chk32("lock_imemload", imemload, 32'h11112222);
    chk1("lock_resp_ramwen", ramWEN, 1'b0);
    imemREN = 1'b0;
    @(negedge CLK);
    chk_st("lock_idle", dbg_state, DMR_IDLE);
    chk1("lock_idle_ramwen", ramWEN, 1'b0);
    @(negedge CLK);
    chk1("wr_ramwen", ramWEN, 1'b1);
    chk1("wr_ramren", ramREN, 1'b0);
    chk32("wr_ramstore", ramstore, 32'h1234);
    chk32("wr_ramaddr", ramaddr, 32'h200);
    wait_hit(1'b1, 20, n);
    chk_int("wr_dhit_lat", n, 5);
    chk32("wr_mem_addr", wr_addr, 32'h200);
    chk32("wr_mem_data", wr_data, 32'h1234);
    dmemWEN = 1'b0; ram_wait = 0;
    @(negedge CLK);

    // RAM ERROR
    chk1("err_pre_memerr", memerr, 1'b0);
    ram_mode = 2; dmemREN = 1'b1; dmemaddr = 32'h104;
    wait_hit(1'b1, 10, n);
    chk_int("err_lat", n, 2);
    chk32("err_load", dmemload, BAD_WORD);
    chk1("err_memerr", memerr, 1'b1);
    dmemREN = 1'b0; ram_mode = 0;
    @(negedge CLK);
    do_reset();
    chk1("err_rst_memerr", memerr, 1'b0);

    // stuck RAM: watchdog abort
    ram_mode = 1; dmemREN = 1'b1; dmemaddr = 32'h108;
    wait_hit(1'b1, 400, n);
    chk_int("wd_lat", n, 257);
    chk32("wd_load", dmemload, BAD_WORD);
    chk1("wd_memerr", memerr, 1'b1);
    dmemREN = 1'b0; ram_mode = 0;
    repeat (5) @(negedge CLK);
    chk1("wd_memerr_sticky", memerr, 1'b1);

    // halt during BUSY_D
    ram_wait = 2; dmemREN = 1'b1; dmemaddr = 32'h300; ram_rdata = 32'h55AA;
    @(negedge CLK);
    chk_st("halt_busy", dbg_state, DMR_BUSY_D);
    halt = 1'b1;
    wait_hit(1'b1, 10, n);
    chk_int("halt_dhit_lat", n, 3);
    chk32("halt_dmemload", dmemload, 32'h55AA);
    dmemREN = 1'b0;
    @(negedge CLK);
    chk_st("halt_idle", dbg_state, DMR_IDLE);
    @(negedge CLK);
    chk_st("halt_halted", dbg_state, DMR_HALTED);
    imemREN = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk1("halt_no_ramren", ramREN, 1'b0);
      chk1("halt_no_ihit", ihit, 1'b0);
    end
    nRST = 1'b1;
    #1;
    chk_st("halt_rst_state", dbg_state, DMR_IDLE);
    chk1("halt_rst_memerr", memerr, 1'b0);
    @(negedge CLK);
    halt = 1'b0; imemREN = 1'b0; ram_wait = 0;
    nRST = 1'b0;

    // reset mid-access drops enables asynchronously, no hit
    ram_mode = 1; imemREN = 1'b1; imemaddr = 32'h80;
    @(negedge CLK);
    chk1("ar_ramren", ramREN, 1'b1);
    #1 nRST = 1'b1;
    #1;
    chk1("ar_ramren_drop", ramREN, 1'b0);
    @(negedge CLK);
    imemREN = 1'b0; ram_mode = 0;
    nRST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk1("ar_no_ihit", ihit, 1'b0);
    end

`ifdef DP_MEM_RESPONDER_STATS_EN
    do_reset();
    chk32("st_rst_icount", icount, 32'h0);
    ram_wait = 1;
    for (int k = 0; k < 3; k++) begin
      imemREN = 1'b1; imemaddr = 32'h400 + 32'(k * 4);
      wait_hit(1'b0, 10, n);
      chk_int("st_ihit_lat", n, 3);
      imemREN = 1'b0;
      @(negedge CLK);
    end
    for (int k = 0; k < 2; k++) begin
      dmemREN = 1'b1; dmemaddr = 32'h500 + 32'(k * 4);
      wait_hit(1'b1, 10, n);
      chk_int("st_dhit_lat", n, 3);
      dmemREN = 1'b0;
      @(negedge CLK);
    end
    chk32("st_icount", icount, 32'd3);
    chk32("st_dcount", dcount, 32'd2);
    chk32("st_stallcount", stallcount, 32'd10);
    ram_wait = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
